instruction_fetch: RTL and testbench

Fetch stage directly upstream of `memory_hierarchy`. It owns the program counter and drives the read handshake (`read_enable`/`address` → `rd_ready`/`inst`) of the memory hierarchy. Returned instructions are buffered in a small queue and presented, with their PC, to the decode stage over a valid/ready interface. A redirect input (branch/jump) flushes the queue and restarts fetch at a new PC.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_queue.sv | 65 ++++++
 rtl/instruction_fetch.sv | 128 ++++++++++++
 tb/tb_instruction_fetch.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage: FSM states, queue entry payload and reset PC.
package fetch_pkg;

    localparam int unsigned FETCH_ADDR_WIDTH = 8;
    localparam int unsigned FETCH_INST_WIDTH = 16;
    localparam int unsigned FETCH_RESET_PC   = 0;

    typedef enum logic [1:0] {
        GAP   = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_ADDR_WIDTH-1:0] pc;
        logic [FETCH_INST_WIDTH-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of fetched {pc, inst} entries with a registered head and a flush that wins over push/pop.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  fetch_entry_t             push_entry,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     head_valid,
    output fetch_entry_t             head_entry
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt;

    logic             do_pop;
    logic             do_push;
    logic [PTR_W-1:0] rd_ptr_n;
    logic [CNT_W-1:0] cnt_n;
    fetch_entry_t     head_n;

    // Next head is computed ahead so the head outputs come straight from flops.
    always_comb begin
        do_pop   = pop && (cnt != '0);
        do_push  = push && ((cnt != CNT_W'(DEPTH)) || do_pop);
        rd_ptr_n = do_pop ? rd_ptr + PTR_W'(1) : rd_ptr;
        cnt_n    = cnt + CNT_W'(do_push) - CNT_W'(do_pop);
        head_n   = (do_push && (wr_ptr == rd_ptr_n)) ? push_entry : mem[rd_ptr_n];
        if (cnt_n == '0) begin
            head_n = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            cnt        <= '0;
            head_valid <= 1'b0;
            head_entry <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            rd_ptr     <= rd_ptr_n;
            cnt        <= cnt_n;
            head_valid <= (cnt_n != '0);
            head_entry <= head_n;
        end
    end

    assign count = cnt;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues one memory request at a time and queues results for decode.
// Optional stall counter is built only when IFETCH_PERF_EN is defined.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH  = FETCH_ADDR_WIDTH,
    parameter int unsigned           INST_WIDTH  = FETCH_INST_WIDTH,
    parameter int unsigned           QUEUE_DEPTH = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(FETCH_RESET_PC)
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  read_enable,
    output logic [ADDR_WIDTH-1:0] address,
    input  logic                  rd_ready,
    input  logic [INST_WIDTH-1:0] inst,
    output logic                  if_valid,
    output logic [INST_WIDTH-1:0] if_inst,
    output logic [ADDR_WIDTH-1:0] if_pc,
    input  logic                  id_ready,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [15:0]           stall_cycles
);

    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;

    fetch_state_t          state;
    logic [ADDR_WIDTH-1:0] pc;

    logic                  q_push;
    logic                  q_pop;
    fetch_entry_t          q_push_entry;
    logic [CNT_W-1:0]      q_count;
    fetch_entry_t          q_head;

    // Only a live request returning without a redirect reaches the queue.
    assign q_push            = (state == FETCH) && rd_ready && !redirect_valid;
    assign q_pop             = if_valid && id_ready;
    assign q_push_entry.pc   = FETCH_ADDR_WIDTH'(pc);
    assign q_push_entry.inst = FETCH_INST_WIDTH'(inst);

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clock      (clock),
        .reset      (reset),
        .push       (q_push),
        .push_entry (q_push_entry),
        .pop        (q_pop),
        .flush      (redirect_valid),
        .count      (q_count),
        .head_valid (if_valid),
        .head_entry (q_head)
    );

    assign if_pc   = ADDR_WIDTH'(q_head.pc);
    assign if_inst = INST_WIDTH'(q_head.inst);

    // Request FSM; read_enable always drops for at least one GAP cycle after a completion.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= GAP;
            pc          <= RESET_PC;
            read_enable <= 1'b0;
            address     <= RESET_PC;
        end else begin
            case (state)
                GAP: begin
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                    end else if (q_count < CNT_W'(QUEUE_DEPTH)) begin
                        state       <= FETCH;
                        read_enable <= 1'b1;
                        address     <= pc;
                    end
                end
                FETCH: begin
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                        if (rd_ready) begin
                            state       <= GAP;
                            read_enable <= 1'b0;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (rd_ready) begin
                        pc          <= pc + ADDR_WIDTH'(1);
                        state       <= GAP;
                        read_enable <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                    end
                    if (rd_ready) begin
                        state       <= GAP;
                        read_enable <= 1'b0;
                    end
                end
                default: begin
                    state       <= GAP;
                    read_enable <= 1'b0;
                end
            endcase
        end
    end

`ifdef IFETCH_PERF_EN
    logic [15:0] stall_q;

    // Saturating count of cycles spent waiting on the memory hierarchy.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_q <= '0;
        end else if (((state == FETCH) || (state == DRAIN)) && !rd_ready
                     && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch with a behavioural memory and an in-order PC stream model.
module tb_instruction_fetch;

    logic        clock = 1'b0;
    logic        reset;
    logic        read_enable;
    logic [7:0]  address;
    logic        rd_ready;
    logic [15:0] inst;
    logic        if_valid;
    logic [15:0] if_inst;
    logic [7:0]  if_pc;
    logic        id_ready;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic [15:0] stall_cycles;

`ifdef IFETCH_PERF_EN
    localparam int STALL_PER_REQ = 2;
`else
    localparam int STALL_PER_REQ = 0;
`endif

    instruction_fetch dut (
        .clock          (clock),
        .reset          (reset),
        .read_enable    (read_enable),
        .address        (address),
        .rd_ready       (rd_ready),
        .inst           (inst),
        .if_valid       (if_valid),
        .if_inst        (if_inst),
        .if_pc          (if_pc),
        .id_ready       (id_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall_cycles   (stall_cycles)
    );

    always #5 clock = ~clock;

    // Memory: answers a request after cur_lat cycles with inst = address + 0x1000.
    int base_lat = 3;
    bit rand_lat = 1'b0;
    int cur_lat  = 3;
    int mcnt     = 0;

    always @(posedge clock) begin
        if (reset) begin
            mcnt    <= 0;
            cur_lat <= base_lat;
        end else if (read_enable) begin
            if (rd_ready) begin
                mcnt    <= 0;
                cur_lat <= rand_lat ? int'($urandom_range(4, 1)) : base_lat;
            end else begin
                mcnt <= mcnt + 1;
            end
        end
    end

    assign rd_ready = read_enable && ((mcnt + 1) >= cur_lat);
    assign inst     = rd_ready ? (16'(address) + 16'h1000) : 16'hDEAD;

    // Observed events: accepted pops and redirects in order, plus request addresses.
    typedef struct {
        bit         redir;
        logic [7:0] pc;
        logic [15:0] ins;
    } ev_t;

    ev_t        ev_q[$];
    logic [7:0] req_q[$];
    int         gap_viol      = 0;
    int         addr_unstable = 0;
    logic       prev_re       = 1'b0;
    logic       prev_rdy      = 1'b0;
    logic [7:0] prev_addr     = 8'h00;

    always @(negedge clock) begin
        if (!reset) begin
            if (read_enable && !prev_re) req_q.push_back(address);
            if (read_enable && prev_re && (address !== prev_addr)) addr_unstable++;
            if (prev_re && prev_rdy && read_enable) gap_viol++;
            if (redirect_valid) ev_q.push_back('{1'b1, redirect_pc, 16'h0000});
            else if (if_valid && id_ready) ev_q.push_back('{1'b0, if_pc, if_inst});
        end
        prev_re   = reset ? 1'b0 : read_enable;
        prev_rdy  = rd_ready;
        prev_addr = address;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic hold_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;
        tick();
        tick();
        ev_q.delete();
        req_q.delete();
    endtask

    function automatic int n_pops();
        int n = 0;
        foreach (ev_q[i]) if (!ev_q[i].redir) n++;
        return n;
    endfunction

    function automatic ev_t pop_at(input int k);
        ev_t r = '{1'b0, 8'hxx, 16'hxxxx};
        int  n = 0;
        foreach (ev_q[i]) begin
            if (!ev_q[i].redir) begin
                if (n == k) r = ev_q[i];
                n++;
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] req_at(input int i);
        logic [7:0] r = 8'hxx;
        if (i < req_q.size()) r = req_q[i];
        return r;
    endfunction

    task automatic wait_pops(input int n, input int budget, input string tag);
        int c = 0;
        while ((n_pops() < n) && (c < budget)) begin
            tick();
            c++;
        end
        check(tag, 32'(n_pops() >= n), 32'd1);
    endtask

    initial begin
        ev_t e;
        int  c;
        logic [7:0] exp_pc;

        id_ready = 1'b0;

        // Reset values
        base_lat = 3;
        hold_reset();
        check("rst_read_enable", 32'(read_enable), 32'd0);
        check("rst_address", 32'(address), 32'h00);
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_if_inst", 32'(if_inst), 32'h0000);
        check("rst_if_pc", 32'(if_pc), 32'h00);
        check("rst_stall", 32'(stall_cycles), 32'd0);

        // Sequential fetch, 3-cycle memory, decode always ready
        id_ready = 1'b1;
        reset    = 1'b0;
        tick();
        check("a_first_re", 32'(read_enable), 32'd1);
        check("a_first_addr", 32'(address), 32'h00);
        tick();
        tick();
        check("a_not_yet_valid", 32'(if_valid), 32'd0);
        tick();
        check("a_push_valid", 32'(if_valid), 32'd1);
        check("a_push_pc", 32'(if_pc), 32'h00);
        check("a_push_inst", 32'(if_inst), 32'h1000);
        check("a_re_fell", 32'(read_enable), 32'd0);
        tick();
        check("a_second_re", 32'(read_enable), 32'd1);
        check("a_second_addr", 32'(address), 32'h01);
        wait_pops(3, 60, "a_pop_timeout");
        for (int i = 0; i < 3; i++) begin
            e = pop_at(i);
            check($sformatf("a_req%0d", i), 32'(req_at(i)), 32'(i));
            check($sformatf("a_pop%0d_pc", i), 32'(e.pc), 32'(i));
            check($sformatf("a_pop%0d_inst", i), 32'(e.ins), 32'h1000 + 32'(i));
        end

        // Back-pressure: queue fills, then one pop allows exactly one new request
        id_ready = 1'b0;
        hold_reset();
        reset = 1'b0;
        repeat (20) tick();
        check("b_idle_re", 32'(read_enable), 32'd0);
        check("b_req_count", 32'(req_q.size()), 32'd2);
        check("b_head_pc", 32'(if_pc), 32'h00);
        check("b_stall", 32'(stall_cycles), 32'(2 * STALL_PER_REQ));
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        check("b_after_pop_pc", 32'(if_pc), 32'h01);
        check("b_after_pop_inst", 32'(if_inst), 32'h1001);
        repeat (20) tick();
        check("b_req_count2", 32'(req_q.size()), 32'd3);
        check("b_third_addr", 32'(req_at(2)), 32'h02);
        check("b_idle_re2", 32'(read_enable), 32'd0);
        check("b_stall2", 32'(stall_cycles), 32'(3 * STALL_PER_REQ));

        // Redirect while a request is outstanding: old data drained and dropped
        base_lat = 4;
        id_ready = 1'b1;
        hold_reset();
        reset = 1'b0;
        tick();
        check("c_re", 32'(read_enable), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 8'h05;
        tick();
        redirect_valid = 1'b0;
        check("c_drain_re", 32'(read_enable), 32'd1);
        check("c_drain_addr", 32'(address), 32'h00);
        wait_pops(2, 60, "c_pop_timeout");
        check("c_req1", 32'(req_at(1)), 32'h05);
        e = pop_at(0);
        check("c_pop0_pc", 32'(e.pc), 32'h05);
        check("c_pop0_inst", 32'(e.ins), 32'h1005);
        e = pop_at(1);
        check("c_pop1_pc", 32'(e.pc), 32'h06);

        // Redirect on the same cycle the memory returns data
        base_lat = 3;
        id_ready = 1'b0;
        hold_reset();
        reset = 1'b0;
        c = 0;
        while (!rd_ready && (c < 10)) begin
            tick();
            c++;
        end
        check("d_rd_ready_seen", 32'(rd_ready), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 8'h03;
        tick();
        redirect_valid = 1'b0;
        check("d_queue_empty", 32'(if_valid), 32'd0);
        check("d_re_low", 32'(read_enable), 32'd0);
        c = 0;
        while (!read_enable && (c < 10)) begin
            tick();
            c++;
        end
        check("d_next_addr", 32'(address), 32'h03);
        c = 0;
        while (!if_valid && (c < 10)) begin
            tick();
            c++;
        end
        check("d_head_pc", 32'(if_pc), 32'h03);
        check("d_head_inst", 32'(if_inst), 32'h1003);

        // PC wrap from 0xFE through 0x00
        base_lat = 2;
        id_ready = 1'b1;
        hold_reset();
        reset          = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 8'hFE;
        tick();
        redirect_valid = 1'b0;
        wait_pops(3, 60, "e_pop_timeout");
        for (int i = 0; i < 3; i++) begin
            exp_pc = 8'hFE + 8'(i);
            e = pop_at(i);
            check($sformatf("e_req%0d", i), 32'(req_at(i)), 32'(exp_pc));
            check($sformatf("e_pop%0d_pc", i), 32'(e.pc), 32'(exp_pc));
            check($sformatf("e_pop%0d_inst", i), 32'(e.ins), 32'(16'(exp_pc) + 16'h1000));
        end

        // Random latency, back-pressure and redirects against the PC stream model
        rand_lat = 1'b1;
        hold_reset();
        reset = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            id_ready       = ($urandom_range(3, 0) != 0);
            redirect_valid = ($urandom_range(40, 0) == 0);
            redirect_pc    = 8'($urandom);
            tick();
        end
        redirect_valid = 1'b0;
        id_ready       = 1'b0;
        tick();
        exp_pc = 8'h00;
        foreach (ev_q[i]) begin
            if (ev_q[i].redir) begin
                exp_pc = ev_q[i].pc;
            end else begin
                check("r_pop_pc", 32'(ev_q[i].pc), 32'(exp_pc));
                check("r_pop_inst", 32'(ev_q[i].ins), 32'(16'(exp_pc) + 16'h1000));
                exp_pc = exp_pc + 8'd1;
            end
        end
        check("r_enough_pops", 32'(n_pops() > 50), 32'd1);

        check("gap_violations", 32'(gap_viol), 32'd0);
        check("addr_unstable", 32'(addr_unstable), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
